// File: rtl/kbd_voice_alloc.sv
// kbd_voice_alloc: PS/2 set-2 byte parser, piano-layout key map and
// NUM_VOICES-slot polyphonic voice allocator with per-voice gate/trigger.
// Optional feature macro: KBD_VOICE_STEAL_EN (steal the oldest voice on overflow).
module kbd_voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_NONE  = 108
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                scan_code,
  input  logic                      scan_valid,
  input  logic [2:0]                GLOBAL_octave,
  output logic [7*NUM_VOICES-1:0]   voice_note,
  output logic [NUM_VOICES-1:0]     voice_gate,
  output logic [NUM_VOICES-1:0]     voice_trig,
  output logic                      overflow
);
  localparam int RW = 3;  // rank width, enough for up to 8 voices

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t                           state_q, state_d;
  logic [NUM_VOICES-1:0][6:0]       note_q, note_d;
  logic [NUM_VOICES-1:0][7:0]       key_q, key_d;
  logic [NUM_VOICES-1:0][RW-1:0]    rank_q, rank_d;
  logic [NUM_VOICES-1:0]            gate_q, gate_d;
  logic [NUM_VOICES-1:0]            trig_q, trig_d;
  logic                             ovf_q, ovf_d;

  logic                             ev_make, ev_brk;
  logic                             km_vld;
  logic [8:0]                       km_ent;   // {octave offset (signed 5b), semitone}
  logic signed [4:0]                km_off, eff;
  logic                             in_range;
  logic [6:0]                       new_note;
  logic [NUM_VOICES-1:0]            key_hit;  // gated voices holding this key code
  logic [NUM_VOICES-1:0]            sel;      // one-hot voice receiving a new note
  logic                             found;
  logic [RW-1:0]                    old_rank;

  assign voice_note = note_q;
  assign voice_gate = gate_q;
  assign voice_trig = trig_q;
  assign overflow   = ovf_q;

  // Parser: classify each byte as make, break, prefix or ignored
  always_comb begin
    state_d = state_q;
    ev_make = 1'b0;
    ev_brk  = 1'b0;
    if (scan_valid) begin
      case (state_q)
        IDLE: begin
          if (scan_code == 8'hF0)      state_d = BRK;
          else if (scan_code == 8'hE0) state_d = EXT;
          else                         ev_make = 1'b1;
        end
        BRK: begin
          if (scan_code == 8'hE0) state_d = EXT_BRK;
          else begin
            ev_brk  = 1'b1;
            state_d = IDLE;
          end
        end
        EXT:     state_d = (scan_code == 8'hF0) ? EXT_BRK : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Key map: scan code -> {octave offset, semitone}
  always_comb begin
    km_vld = 1'b1;
    km_ent = 9'd0;
    case (scan_code)
      8'h15: km_ent = {5'd0, 4'd0};   8'h1E: km_ent = {5'd0, 4'd1};
      8'h1D: km_ent = {5'd0, 4'd2};   8'h26: km_ent = {5'd0, 4'd3};
      8'h24: km_ent = {5'd0, 4'd4};   8'h2D: km_ent = {5'd0, 4'd5};
      8'h2E: km_ent = {5'd0, 4'd6};   8'h2C: km_ent = {5'd0, 4'd7};
      8'h36: km_ent = {5'd0, 4'd8};   8'h35: km_ent = {5'd0, 4'd9};
      8'h3D: km_ent = {5'd0, 4'd10};  8'h3C: km_ent = {5'd0, 4'd11};
      8'h43: km_ent = {5'd1, 4'd0};   8'h46: km_ent = {5'd1, 4'd1};
      8'h44: km_ent = {5'd1, 4'd2};   8'h45: km_ent = {5'd1, 4'd3};
      8'h4D: km_ent = {5'd1, 4'd4};   8'h54: km_ent = {5'd1, 4'd5};
      8'h55: km_ent = {5'd1, 4'd6};   8'h5B: km_ent = {5'd1, 4'd7};
      8'h1A: km_ent = {5'h1F, 4'd0};  8'h1B: km_ent = {5'h1F, 4'd1};
      8'h22: km_ent = {5'h1F, 4'd2};  8'h23: km_ent = {5'h1F, 4'd3};
      8'h21: km_ent = {5'h1F, 4'd4};  8'h2A: km_ent = {5'h1F, 4'd5};
      8'h34: km_ent = {5'h1F, 4'd6};  8'h32: km_ent = {5'h1F, 4'd7};
      8'h33: km_ent = {5'h1F, 4'd8};  8'h31: km_ent = {5'h1F, 4'd9};
      8'h3B: km_ent = {5'h1F, 4'd10}; 8'h3A: km_ent = {5'h1F, 4'd11};
      8'h41: km_ent = {5'h1E, 4'd0};  8'h4B: km_ent = {5'h1E, 4'd1};
      8'h49: km_ent = {5'h1E, 4'd2};  8'h4C: km_ent = {5'h1E, 4'd3};
      8'h4A: km_ent = {5'h1E, 4'd4};
      default: km_vld = 1'b0;
    endcase
  end

  assign km_off   = $signed(km_ent[8:4]);
  assign eff      = $signed({2'b00, GLOBAL_octave}) + km_off;
  assign in_range = (eff >= 5'sd0) && (eff <= 5'sd8);
  assign new_note = 7'(km_ent[3:0]) + 7'(eff[3:0]) * 7'd12;

  // Allocation: break releases by key code, make picks lowest free voice
  always_comb begin
    note_d   = note_q;
    key_d    = key_q;
    rank_d   = rank_q;
    gate_d   = gate_q;
    trig_d   = '0;
    ovf_d    = 1'b0;
    sel      = '0;
    found    = 1'b0;
    old_rank = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      key_hit[i] = gate_q[i] && (key_q[i] == scan_code);

    if (ev_brk) gate_d = gate_q & ~key_hit;

    // a repeat of a held key changes nothing, even after an octave change
    if (ev_make && km_vld && in_range && !(|key_hit)) begin
      for (int i = 0; i < NUM_VOICES; i++)
        if (!gate_q[i] && !found) begin
          sel[i] = 1'b1;
          found  = 1'b1;
        end
      if (!found) begin
        ovf_d = 1'b1;
`ifdef KBD_VOICE_STEAL_EN
        for (int i = 0; i < NUM_VOICES; i++)
          if (rank_q[i] == '0) sel[i] = 1'b1;
`endif
      end
    end

    for (int i = 0; i < NUM_VOICES; i++)
      if (sel[i]) old_rank = old_rank | rank_q[i];

    if (|sel) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (sel[i]) begin
          note_d[i] = new_note;
          key_d[i]  = scan_code;
          gate_d[i] = 1'b1;
          trig_d[i] = 1'b1;
          rank_d[i] = RW'(NUM_VOICES - 1);
        end else if (rank_q[i] > old_rank) begin
          rank_d[i] = rank_q[i] - 1'b1;
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gate_q  <= '0;
      trig_q  <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= 7'(NOTE_NONE);
        key_q[i]  <= 8'h00;
        rank_q[i] <= RW'(i);
      end
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      key_q   <= key_d;
      rank_q  <= rank_d;
      gate_q  <= gate_d;
      trig_q  <= trig_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
